cfg_write_arbiter: RTL and testbench

CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

---
 rtl/cfg_pkg.sv | 14 +
 rtl/rr_arb2.sv | 31 +++
 rtl/cfg_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_cfg_write_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared widths, default register count and FSM state type for the
// configuration write arbiter.
package cfg_pkg;

    localparam int ADDR_W           = 7;
    localparam int DATA_W           = 8;
    localparam int NUM_REGS_DEFAULT = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is requester A and bit 1 is
// requester B. On a tie, the requester that was not granted most recently
// wins. The pointer starts at B, so A wins the first tie after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_b;

    // One-hot grant; on a tie the pointer picks the requester that did not go last.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_b ? 2'b01 : 2'b10;
        end
    end

    // The pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_b <= grant[1];
        end
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Arbitrates configuration writes from the SPI side (A) and the local/debug
// port (B) into a small byte-wide register bank.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | ready offered to one requester; the winner is captured on accept
//   ST_WRITE | held write is applied, or flagged as an error if the address is out of range
module cfg_write_arbiter
    import cfg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] data4,
    output logic              err_pulse,
    output logic              err_src,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_REGS - 1);

    arb_state_t        state, state_nxt;
    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              hold_src;
    logic              hold_err;
    logic              err_src_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] data_vec [5];

    // Requests are offered only in IDLE and never while reset is asserted,
    // so both readies are low during reset.
    assign arb_req = (state == ST_IDLE && rst_n) ? {b_valid, a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    assign a_ready  = grant[0];
    assign b_ready  = grant[1];
    assign accept   = |grant;
    assign hold_err = (hold_addr > MAX_ADDR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: an accepted write takes exactly one WRITE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winning request on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_src  <= 1'b0;
        end else if (accept) begin
            hold_src  <= grant[1];
            hold_addr <= grant[1] ? b_addr : a_addr;
            hold_data <= grant[1] ? b_data : a_data;
        end
    end

    // Apply the held write at the end of WRITE when the address is in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (state == ST_WRITE && !hold_err) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (hold_addr == ADDR_W'(k)) begin
                    regs[k] <= hold_data;
                end
            end
        end
    end

    // Remember the source of the most recent out-of-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_src_q <= 1'b0;
        end else if (state == ST_WRITE && hold_err) begin
            err_src_q <= hold_src;
        end
    end

    assign busy      = (state == ST_WRITE);
    assign err_pulse = (state == ST_WRITE) && hold_err;
    // The new source is already visible during the error pulse.
    assign err_src   = err_pulse ? hold_src : err_src_q;

    // Map the bank to the five fixed outputs. Outputs beyond the bank read zero.
    for (genvar k = 0; k < 5; k++) begin : g_out
        if (k < NUM_REGS) begin : g_map
            assign data_vec[k] = regs[k];
        end else begin : g_zero
            assign data_vec[k] = '0;
        end
    end

    assign data0 = data_vec[0];
    assign data1 = data_vec[1];
    assign data2 = data_vec[2];
    assign data3 = data_vec[3];
    assign data4 = data_vec[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter. Directed cases are followed by randomized
// traffic. A cycle-level model tracks readies and busy and queues each
// expected write. A separate monitor pops the queue whenever the DUT is
// busy, and keeps a shadow copy of the register bank.
module tb_cfg_write_arbiter;

    localparam int NREG = 5;
    localparam int MAXA = NREG - 1;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } item_t;

    typedef struct {
        bit         src;
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [6:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready;
    logic [7:0] data0, data1, data2, data3, data4;
    logic       err_pulse, err_src, busy;
    logic [7:0] dq [NREG];

    item_t qa[$], qb[$];
    wr_t   exp_q[$];
    logic [7:0] shadow [NREG];
    bit    exp_err_src;
    bit    m_busy, m_last_b;
    int    n_cmp = 0, n_bad = 0;

    cfg_write_arbiter #(.NUM_REGS(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .err_pulse(err_pulse), .err_src(err_src), .busy(busy)
    );

    assign dq[0] = data0;
    assign dq[1] = data1;
    assign dq[2] = data2;
    assign dq[3] = data3;
    assign dq[4] = data4;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [6:0] addr, input logic [7:0] data);
        item_t it;
        it.addr = addr;
        it.data = data;
        return it;
    endfunction

    function automatic wr_t mk_wr(input bit src, input item_t it);
        wr_t w;
        w.src  = src;
        w.addr = it.addr;
        w.data = it.data;
        return w;
    endfunction

    function automatic item_t rand_item();
        logic [6:0] a;
        if ($urandom_range(0, 5) == 0) a = 7'($urandom_range(NREG, 127));
        else                           a = 7'($urandom_range(0, MAXA));
        return mk(a, 8'($urandom));
    endfunction

    task automatic drive();
        a_valid = (qa.size() != 0);
        b_valid = (qb.size() != 0);
        if (a_valid) begin a_addr = qa[0].addr; a_data = qa[0].data; end
        else         begin a_addr = 7'($urandom); a_data = 8'($urandom); end
        if (b_valid) begin b_addr = qb[0].addr; b_data = qb[0].data; end
        else         begin b_addr = 7'($urandom); b_data = 8'($urandom); end
    endtask

    // Called at posedge+1. Runs n cycles of model-checked traffic.
    task automatic run(input int n, input bit rnd);
        bit ea, eb;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                if (qa.size() == 0 && $urandom_range(0, 9) < 5) qa.push_back(rand_item());
                if (qb.size() == 0 && $urandom_range(0, 9) < 5) qb.push_back(rand_item());
            end
            drive();
            @(negedge clk);
            ea = 1'b0;
            eb = 1'b0;
            if (!m_busy) begin
                if (a_valid && b_valid) begin
                    if (m_last_b) ea = 1'b1;
                    else          eb = 1'b1;
                end else begin
                    ea = a_valid;
                    eb = b_valid;
                end
            end
            check("a_ready", a_ready, ea);
            check("b_ready", b_ready, eb);
            check("busy", busy, m_busy);
            if (ea) begin exp_q.push_back(mk_wr(1'b0, qa[0])); m_last_b = 1'b0; end
            if (eb) begin exp_q.push_back(mk_wr(1'b1, qb[0])); m_last_b = 1'b1; end
            m_busy = ea | eb;
            @(posedge clk);
            #1;
            if (ea) void'(qa.pop_front());
            if (eb) void'(qb.pop_front());
        end
    endtask

    // Called at posedge+1. Pulses reset across one falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_src", err_src, 1'b0);
        for (int k = 0; k < NREG; k++) check($sformatf("rst_data%0d", k), dq[k], 8'h00);
        qa.delete();
        qb.delete();
        m_busy = 1'b0;
        m_last_b = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the bank every cycle, and consume one expected write per busy cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int k = 0; k < NREG; k++) shadow[k] = 8'h00;
            exp_err_src = 1'b0;
        end else begin
            for (int k = 0; k < NREG; k++) check($sformatf("data%0d", k), dq[k], shadow[k]);
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    bit  e;
                    w = exp_q.pop_front();
                    e = (int'(w.addr) > MAXA);
                    check("err_pulse", err_pulse, e);
                    if (e) exp_err_src = w.src;
                    check("err_src", err_src, exp_err_src);
                    if (!e) shadow[int'(w.addr)] = w.data;
                end
            end else begin
                check("err_pulse_idle", err_pulse, 1'b0);
                check("err_src_idle", err_src, exp_err_src);
            end
        end
    end

    initial begin
        #2;
        pulse_reset();

        // Single write from A to address 2.
        qa.push_back(mk(7'd2, 8'hA5));
        run(4, 1'b0);

        // Tie right after reset: A goes first, then B.
        pulse_reset();
        qa.push_back(mk(7'd0, 8'h11));
        qb.push_back(mk(7'd1, 8'h22));
        run(5, 1'b0);

        // Both requesters hold valid for six writes; grants alternate.
        for (int k = 0; k < 3; k++) begin
            qa.push_back(mk(7'(k), 8'(8'h30 + k)));
            qb.push_back(mk(7'(k + 2), 8'(8'h40 + k)));
        end
        run(14, 1'b0);

        // Out-of-range writes from B and then A.
        qb.push_back(mk(7'd5, 8'hFF));
        run(3, 1'b0);
        qa.push_back(mk(7'd127, 8'h77));
        run(3, 1'b0);

        // Reset arrives while the write to address 4 is held.
        qa.push_back(mk(7'd4, 8'h3C));
        run(1, 1'b0);
        pulse_reset();
        qa.push_back(mk(7'd0, 8'h5A));
        qb.push_back(mk(7'd1, 8'h6B));
        run(5, 1'b0);

        // Random traffic, then drain.
        run(400, 1'b1);
        run(6, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
